// File: rtl/nco_sincos.sv
// Phase-accumulator NCO: one sin/cos pair per accepted step, one shared
// quarter-wave ROM read twice over a 4-state FSM.
//  clk, reset_n                  : clock, async active-low reset
//  phase_inc, phase_inc_we       : increment value and its load strobe
//  phase_sync                    : force accumulator to zero
//  step / busy                   : sample request / FSM not idle
//  out_valid, cos_o, sin_o, wrap_o : result pulse, samples, carry flag
//  phase_o                       : current accumulator value
module nco_sincos #(
  parameter int PHASE_W    = 24,
  parameter int LUT_ABITS  = 8,
  parameter int OUT_W      = 8,
  parameter int OFFSET_BIN = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               phase_inc_we,
  input  logic               phase_sync,
  input  logic               step,
  output logic               busy,
  output logic               out_valid,
  output logic [OUT_W-1:0]   cos_o,
  output logic [OUT_W-1:0]   sin_o,
  output logic               wrap_o,
  output logic [PHASE_W-1:0] phase_o
);

  localparam int IW = LUT_ABITS + 2;
  localparam int MW = OUT_W - 1;
  localparam int N  = 2 ** LUT_ABITS;
  localparam logic [IW-1:0] QOFF = IW'(N);
  localparam logic [OUT_W-1:0] MID =
    (OFFSET_BIN != 0) ? {1'b1, {MW{1'b0}}} : '0;
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    IDLE, RD_COS, RD_SIN, OUT
  } state_t;

  // Elaboration-time table value: Taylor cosine, then a
  // binary search for the floor so the clamp falls out free.
  function automatic int rom_val(input int k);
    real x, t, c, y;
    int  lo, hi, mid;
    x = (real'(k) + 0.5) * PI / real'(2 ** (LUT_ABITS + 1));
    c = 1.0;
    t = 1.0;
    for (int n = 1; n <= 20; n++) begin
      t = -t * x * x / real'((2 * n - 1) * (2 * n));
      c = c + t;
    end
    y  = c * real'(2 ** MW);
    lo = 0;
    hi = 2 ** MW - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (real'(mid) <= y) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  logic [MW-1:0] w_rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam int V = rom_val(k);
    assign w_rom[k] = V[MW-1:0];
  end

  state_t             r_state;
  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_inc;
  logic [IW-1:0]      r_idx;
  logic               r_wrap_pend;
  logic [MW-1:0]      r_rom;
  logic [MW-1:0]      r_cos_m;
  logic [OUT_W-1:0]   r_cos;
  logic [OUT_W-1:0]   r_sin;
  logic               r_wrap;
  logic               r_valid;
  logic               r_busy;

  logic [PHASE_W-1:0]   w_inc;
  logic [PHASE_W:0]     w_sum;
  logic                 w_accept;
  logic [IW-1:0]        w_sin_j;
  logic [LUT_ABITS-1:0] w_cos_addr;
  logic [LUT_ABITS-1:0] w_sin_addr;
  logic [LUT_ABITS-1:0] w_addr;
  logic                 w_cos_neg;
  logic                 w_sin_neg;
  logic                 w_sign_c;
  logic                 w_sign_s;

  // A load on the accept edge must already apply.
  assign w_inc    = phase_inc_we ? phase_inc : r_inc;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_inc};
  assign w_accept = step && (r_state == IDLE);

  // Sine is cosine shifted back a quarter turn.
  assign w_sin_j = r_idx - QOFF;

  assign w_cos_addr = r_idx[LUT_ABITS-1:0]
                    ^ {LUT_ABITS{r_idx[IW-2]}};
  assign w_sin_addr = w_sin_j[LUT_ABITS-1:0]
                    ^ {LUT_ABITS{w_sin_j[IW-2]}};
  assign w_cos_neg  = r_idx[IW-1] ^ r_idx[IW-2];
  assign w_sin_neg  = w_sin_j[IW-1] ^ w_sin_j[IW-2];

  assign w_addr = (r_state == RD_SIN) ? w_sin_addr
                                      : w_cos_addr;

  assign w_sign_c = (OFFSET_BIN != 0) ? ~w_cos_neg : w_cos_neg;
  assign w_sign_s = (OFFSET_BIN != 0) ? ~w_sin_neg : w_sin_neg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_inc       <= '0;
      r_idx       <= '0;
      r_wrap_pend <= 1'b0;
      r_rom       <= '0;
      r_cos_m     <= '0;
      r_cos       <= MID;
      r_sin       <= MID;
      r_wrap      <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_rom   <= w_rom[w_addr];
      if (phase_inc_we) r_inc <= phase_inc;
      if (phase_sync) r_acc <= '0;
      else if (w_accept) r_acc <= w_sum[PHASE_W-1:0];
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx <= phase_sync ? '0
                   : w_sum[PHASE_W-1 -: IW];
            r_wrap_pend <= !phase_sync && w_sum[PHASE_W];
            r_busy  <= 1'b1;
            r_state <= RD_COS;
          end
        end
        RD_COS: r_state <= RD_SIN;
        RD_SIN: begin
          r_cos_m <= r_rom;
          r_state <= OUT;
        end
        OUT: begin
          r_cos   <= {w_sign_c, r_cos_m ^ {MW{w_cos_neg}}};
          r_sin   <= {w_sign_s, r_rom ^ {MW{w_sin_neg}}};
          r_wrap  <= r_wrap_pend;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign cos_o     = r_cos;
  assign sin_o     = r_sin;
  assign wrap_o    = r_wrap;
  assign phase_o   = r_acc;

endmodule

// File: tb/tb_nco_sincos.sv
// Directed bench for nco_sincos: default, two's-complement
// and small-table instances.
module tb_nco_sincos;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] phase_inc;
  logic        phase_inc_we;
  logic        phase_sync;
  logic        step;
  logic        step1;
  logic        busy, out_valid, wrap_o;
  logic [7:0]  cos_o, sin_o;
  logic [23:0] phase_o;
  logic        busy1, out_valid1, wrap1;
  logic [7:0]  cos1, sin1;
  logic [23:0] phase1;
  logic [23:0] z_inc;
  logic        z_bit;
  logic        busy2, out_valid2, wrap2;
  logic [11:0] cos2, sin2;
  logic [23:0] phase2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nco_sincos dut (
    .clk(clk), .reset_n(reset_n),
    .phase_inc(phase_inc), .phase_inc_we(phase_inc_we),
    .phase_sync(phase_sync), .step(step),
    .busy(busy), .out_valid(out_valid),
    .cos_o(cos_o), .sin_o(sin_o),
    .wrap_o(wrap_o), .phase_o(phase_o)
  );

  nco_sincos #(.OFFSET_BIN(0)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .phase_inc(phase_inc), .phase_inc_we(phase_inc_we),
    .phase_sync(phase_sync), .step(step1),
    .busy(busy1), .out_valid(out_valid1),
    .cos_o(cos1), .sin_o(sin1),
    .wrap_o(wrap1), .phase_o(phase1)
  );

  nco_sincos #(.LUT_ABITS(6), .OUT_W(12)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .phase_inc(z_inc), .phase_inc_we(z_bit),
    .phase_sync(z_bit), .step(z_bit),
    .busy(busy2), .out_valid(out_valid2),
    .cos_o(cos2), .sin_o(sin2),
    .wrap_o(wrap2), .phase_o(phase2)
  );

  typedef struct {
    logic [23:0] inc;
    logic        sync;
    logic [7:0]  c;
    logic [7:0]  s;
    logic        w;
    logic [23:0] ph;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic run_step(input logic [23:0] inc,
                          input logic sync,
                          input logic sel,
                          output int lat);
    phase_inc    = inc;
    phase_inc_we = 1'b1;
    phase_sync   = sync;
    step         = !sel;
    step1        = sel;
    tick();
    phase_inc_we = 1'b0;
    phase_sync   = 1'b0;
    step         = 1'b0;
    step1        = 1'b0;
    check("busy_after_accept", sel ? busy1 : busy, 1);
    lat = 0;
    while (!(sel ? out_valid1 : out_valid) && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, pulses, p0, p1, e;
    real r;
    reset_n      = 1'b0;
    phase_inc    = '0;
    phase_inc_we = 1'b0;
    phase_sync   = 1'b0;
    step         = 1'b0;
    step1        = 1'b0;
    z_inc        = '0;
    z_bit        = 1'b0;

    vt[0] = '{24'h000000, 0, 8'hFF, 8'h80, 0, 24'h000000};
    vt[1] = '{24'h400000, 0, 8'h7F, 8'hFF, 0, 24'h400000};
    vt[2] = '{24'h400000, 0, 8'h00, 8'h7F, 0, 24'h800000};
    vt[3] = '{24'h400000, 0, 8'h80, 8'h00, 0, 24'hC00000};
    vt[4] = '{24'h400000, 0, 8'hFF, 8'h80, 1, 24'h000000};
    vt[5] = '{24'h200000, 0, 8'hDA, 8'hDA, 0, 24'h200000};
    vt[6] = '{24'hF00000, 0, 8'hF6, 8'hB1, 1, 24'h100000};
    vt[7] = '{24'h123456, 1, 8'hFF, 8'h80, 0, 24'h000000};

    tick();
    tick();
    check("rst_cos", cos_o, 8'h80);
    check("rst_sin", sin_o, 8'h80);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_phase", phase_o, 0);
    check("rst_cos_tc", cos1, 8'h00);
    check("rst_sin_tc", sin1, 8'h00);
    reset_n = 1'b1;
    tick();
    check("rst_wrap", wrap_o, 0);

    for (int i = 0; i < 8; i++) begin
      run_step(vt[i].inc, vt[i].sync, 1'b0, lat);
      check($sformatf("v%0d_lat", i), lat, 3);
      check($sformatf("v%0d_cos", i), cos_o, vt[i].c);
      check($sformatf("v%0d_sin", i), sin_o, vt[i].s);
      check($sformatf("v%0d_wrap", i), wrap_o, vt[i].w);
      check($sformatf("v%0d_phase", i), phase_o, vt[i].ph);
      check($sformatf("v%0d_busy", i), busy, 0);
      tick();
      check($sformatf("v%0d_pulse", i), out_valid, 0);
    end

    // step held high: later requests dropped while busy
    do_reset();
    phase_inc    = 24'h010000;
    phase_inc_we = 1'b1;
    step         = 1'b1;
    pulses = 0;
    p0 = -1;
    p1 = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) begin
        if (pulses == 0) p0 = i;
        else p1 = i;
        pulses++;
      end
    end
    step         = 1'b0;
    phase_inc_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("hold_pulses", pulses, 2);
    check("hold_first", p0, 3);
    check("hold_second", p1, 7);
    check("hold_phase", phase_o, 24'h020000);

    // reset in RD_SIN aborts the sample
    phase_inc    = 24'h400000;
    phase_inc_we = 1'b1;
    step         = 1'b1;
    tick();
    phase_inc_we = 1'b0;
    step         = 1'b0;
    tick();
    check("abort_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_cos", cos_o, 8'h80);
    check("abort_sin", sin_o, 8'h80);
    check("abort_busy0", busy, 0);
    check("abort_phase", phase_o, 0);
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("abort_no_valid", pulses, 0);

    // phase_sync with step from a non-zero accumulator
    run_step(24'h123456, 1'b0, 1'b0, lat);
    check("sync_pre_phase", phase_o, 24'h123456);
    run_step(24'h123456, 1'b1, 1'b0, lat);
    check("sync_lat", lat, 3);
    check("sync_phase", phase_o, 0);
    check("sync_cos", cos_o, 8'hFF);
    check("sync_sin", sin_o, 8'h80);
    check("sync_wrap", wrap_o, 0);

    // two's-complement instance
    do_reset();
    run_step(24'h800000, 1'b0, 1'b1, lat);
    check("tc1_lat", lat, 3);
    check("tc1_cos", cos1, 8'h80);
    check("tc1_sin", sin1, 8'hFF);
    check("tc1_wrap", wrap1, 0);
    tick();
    run_step(24'h800000, 1'b0, 1'b1, lat);
    check("tc2_cos", cos1, 8'h7F);
    check("tc2_sin", sin1, 8'h00);
    check("tc2_wrap", wrap1, 1);
    check("tc2_phase", phase1, 0);

    // small-table ROM against the closed form
    for (int k = 0; k < 64; k++) begin
      r = 2048.0 * $cos((real'(k) + 0.5)
          * 3.14159265358979323846 / 128.0);
      e = $rtoi($floor(r));
      if (e > 2047) e = 2047;
      check($sformatf("rom6_%0d", k),
            32'(dut2.w_rom[k]), e[31:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
